// File: rtl/store_drain_if.sv
// Store, load-probe and memory-write signals of the post-commit store drain buffer.
// Handshakes: a transfer happens on a rising clk edge where valid (st_valid / mem_write) and
// ready (st_ready / mem_ready) are both 1; the valid side holds its payload stable until then.
`timescale 1ns/1ps
interface store_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  st_valid;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_ready;
  logic                  ld_probe_valid;
  logic [ADDR_WIDTH-1:0] ld_probe_addr;
  logic                  ld_fwd_hit;
  logic [DATA_WIDTH-1:0] ld_fwd_data;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;

  modport master (
    output st_valid, st_addr, st_data, ld_probe_valid, ld_probe_addr, mem_ready,
    input  st_ready, ld_fwd_hit, ld_fwd_data, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_probe_valid, ld_probe_addr, mem_ready,
    output st_ready, ld_fwd_hit, ld_fwd_data, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: circular FIFO of retired stores drained one at a time to memory,
// with youngest-match store-to-load forwarding and drain performance counters.
`timescale 1ns/1ps
module store_drain_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  store_drain_if.slave                 sb,
  output logic                         sb_empty,
  output logic [$clog2(SB_DEPTH):0]    sb_count,
  output logic [CNT_WIDTH-1:0]         stores_drained,
  output logic [CNT_WIDTH-1:0]         drain_stall_cycles,
  output logic                         dbg_state
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ent_addr [SB_DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [SB_DEPTH];
  logic [SB_DEPTH-1:0]   ent_valid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  enq;
  logic                  pop;

  assign sb.st_ready  = (count < CW'(SB_DEPTH));
  assign enq          = sb.st_valid && sb.st_ready;
  assign pop          = (state == WRITE) && sb.mem_ready;
  assign sb.mem_write = (state == WRITE);
  // Head entry is only presented while a write is outstanding; the bus idles at zero.
  assign sb.mem_addr  = (state == WRITE) ? ent_addr[head] : '0;
  assign sb.mem_wdata = (state == WRITE) ? ent_data[head] : '0;
  assign sb_empty     = (count == '0);
  assign sb_count     = count;
  assign dbg_state    = (state == WRITE);

  always_comb begin
    count_next = count;
    case ({enq, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      ent_valid          <= '0;
      state              <= IDLE;
      stores_drained     <= '0;
      drain_stall_cycles <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
        stores_drained  <= stores_drained + CNT_WIDTH'(1);
      end
      if (enq) begin
        ent_addr[tail]  <= sb.st_addr;
        ent_data[tail]  <= sb.st_data;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      count <= count_next;
      if ((state == WRITE) && !sb.mem_ready && (drain_stall_cycles != {CNT_WIDTH{1'b1}}))
        drain_stall_cycles <= drain_stall_cycles + CNT_WIDTH'(1);
      case (state)
        IDLE:    if (count != '0) state <= WRITE;
        WRITE:   if (sb.mem_ready && (count_next == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins; same-cycle enqueues are not yet valid.
  always_comb begin
    logic [PW-1:0] idx;
    idx            = '0;
    sb.ld_fwd_hit  = 1'b0;
    sb.ld_fwd_data = '0;
    if (sb.ld_probe_valid) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        idx = head + PW'(i);
        if (ent_valid[idx] && (ent_addr[idx] == sb.ld_probe_addr)) begin
          sb.ld_fwd_hit  = 1'b1;
          sb.ld_fwd_data = ent_data[idx];
        end
      end
    end
  end
endmodule
